// File: rtl/decode_job_sched.sv
// Decode job scheduler: NBANK bank-pair ring, in-order dispatch to a single
// decoder core with an optional watchdog, and in-order result retirement.
module decode_job_slot #(
  parameter int BANK_W = 1,
  parameter int MODE_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic              fin_en,
  input  logic              fin_err,
  output logic [BANK_W-1:0] bank,
  output logic [MODE_W-1:0] mode,
  output logic              err,
  output logic              done
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
      mode <= '0;
      err  <= 1'b0;
      done <= 1'b0;
    end else if (wr_en) begin
      bank <= wr_bank;
      mode <= wr_mode;
      err  <= 1'b0;
      done <= 1'b0;
    end else if (fin_en) begin
      done <= 1'b1;
      err  <= fin_err;
    end
  end
endmodule

module decode_job_sched #(
  parameter int NBANK   = 2,
  parameter int BANK_W  = 1,
  parameter int MODE_W  = 1,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fill_valid,
  output logic [BANK_W-1:0] fill_bank,
  input  logic              job_commit,
  input  logic [MODE_W-1:0] job_mode,
  output logic              core_start,
  output logic [BANK_W-1:0] core_bank,
  output logic [MODE_W-1:0] core_mode,
  input  logic              core_done,
  output logic              core_abort,
  output logic              res_valid,
  output logic [BANK_W-1:0] res_bank,
  output logic [MODE_W-1:0] res_mode,
  output logic              res_err,
  input  logic              res_ack,
  output logic              busy,
  output logic [BANK_W:0]   pending,
  output logic              commit_err
);
  localparam int PW = BANK_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
  state_t state, state_nxt;

  // Pointers carry one wrap bit so a full ring is distinguishable from empty.
  logic [PW-1:0]     wr_ptr, dsp_ptr, rd_ptr;
  logic [BANK_W-1:0] wr_idx, dsp_idx, rd_idx;
  logic [NBANK-1:0]  in_use, use_set, use_clr;
  logic [TMO_W-1:0]  wdog;
  logic              commit_ok, ack_ok, dsp_req, expire, fin, fin_err;

  logic [BANK_W-1:0] slot_bank [NBANK];
  logic [MODE_W-1:0] slot_mode [NBANK];
  logic [NBANK-1:0]  slot_err, slot_done;

  assign wr_idx  = wr_ptr[BANK_W-1:0];
  assign dsp_idx = dsp_ptr[BANK_W-1:0];
  assign rd_idx  = rd_ptr[BANK_W-1:0];

  assign pending   = wr_ptr - rd_ptr;
  assign dsp_req   = (dsp_ptr != wr_ptr);
  assign res_valid = slot_done[rd_idx] && (pending != '0);
  assign res_bank  = slot_bank[rd_idx];
  assign res_mode  = slot_mode[rd_idx];
  assign res_err   = slot_err[rd_idx];
  assign commit_ok = job_commit && fill_valid;
  assign ack_ok    = res_ack && res_valid;
  assign expire    = (TMO_CYC != 0) && (state == S_WAIT) &&
                     (wdog == TMO_W'(TMO_CYC - 1));

  // Lowest-index free bank wins.
  always_comb begin
    fill_valid = 1'b0;
    fill_bank  = '0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        fill_valid = 1'b1;
        fill_bank  = BANK_W'(i);
      end
    end
  end

  always_comb begin
    use_set = '0;
    use_clr = '0;
    if (commit_ok) use_set[fill_bank] = 1'b1;
    if (ack_ok)    use_clr[res_bank]  = 1'b1;
  end

  for (genvar i = 0; i < NBANK; i++) begin : g_slot
    decode_job_slot #(.BANK_W(BANK_W), .MODE_W(MODE_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (commit_ok && (wr_idx == BANK_W'(i))),
      .wr_bank (fill_bank),
      .wr_mode (job_mode),
      .fin_en  (fin && (dsp_idx == BANK_W'(i))),
      .fin_err (fin_err),
      .bank    (slot_bank[i]),
      .mode    (slot_mode[i]),
      .err     (slot_err[i]),
      .done    (slot_done[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dsp_req) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (core_done || expire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A completion on the last watchdog cycle counts as a clean finish.
  always_comb begin
    core_start = (state == S_START);
    busy       = (state != S_IDLE);
    fin        = (state == S_WAIT) && (core_done || expire);
    fin_err    = !core_done;
    core_abort = expire && !core_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      dsp_ptr    <= '0;
      rd_ptr     <= '0;
      in_use     <= '0;
      wdog       <= '0;
      core_bank  <= '0;
      core_mode  <= '0;
      commit_err <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(commit_ok);
      rd_ptr  <= rd_ptr + PW'(ack_ok);
      dsp_ptr <= dsp_ptr + PW'(fin);
      in_use  <= (in_use | use_set) & ~use_clr;
      if (job_commit && !fill_valid) commit_err <= 1'b1;
      if (state == S_IDLE && dsp_req) begin
        core_bank <= slot_bank[dsp_idx];
        core_mode <= slot_mode[dsp_idx];
      end
      if (state == S_START)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_job_sched.sv
// Bench for decode_job_sched: directed scenarios and random traffic on a
// 2-bank watchdogged instance against a job-level model, plus a 4-bank check.
module tb_decode_job_sched;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-bank instance, watchdog on
  logic       job_commit, job_mode, core_done, res_ack;
  logic       fill_valid, core_start, core_abort, res_valid, res_err, busy, commit_err;
  logic [0:0] fill_bank, core_bank, res_bank;
  logic       core_mode, res_mode;
  logic [1:0] pending;

  decode_job_sched #(.NBANK(2), .BANK_W(1), .MODE_W(1), .TMO_W(16), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .fill_valid(fill_valid), .fill_bank(fill_bank),
    .job_commit(job_commit), .job_mode(job_mode), .core_start(core_start),
    .core_bank(core_bank), .core_mode(core_mode), .core_done(core_done),
    .core_abort(core_abort), .res_valid(res_valid), .res_bank(res_bank),
    .res_mode(res_mode), .res_err(res_err), .res_ack(res_ack), .busy(busy),
    .pending(pending), .commit_err(commit_err));

  // 4-bank instance, watchdog off
  logic       b_commit, b_mode, b_done, b_ack;
  logic       b_fill_valid, b_core_start, b_core_abort, b_res_valid, b_res_err, b_busy, b_commit_err;
  logic [1:0] b_fill_bank, b_core_bank, b_res_bank;
  logic       b_core_mode, b_res_mode;
  logic [2:0] b_pending;

  decode_job_sched #(.NBANK(4), .BANK_W(2), .MODE_W(1), .TMO_W(16), .TMO_CYC(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .fill_valid(b_fill_valid), .fill_bank(b_fill_bank),
    .job_commit(b_commit), .job_mode(b_mode), .core_start(b_core_start),
    .core_bank(b_core_bank), .core_mode(b_core_mode), .core_done(b_done),
    .core_abort(b_core_abort), .res_valid(b_res_valid), .res_bank(b_res_bank),
    .res_mode(b_res_mode), .res_err(b_res_err), .res_ack(b_ack), .busy(b_busy),
    .pending(b_pending), .commit_err(b_commit_err));

  int n_tot = 0;
  int n_bad = 0;
  int t;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", tag, t, got, exp);
    end
  endtask

  // Job-level model: jobs in commit order; the first ndone of them are finished.
  typedef struct {int bank; int mode; int cc; bit err;} job_t;
  job_t q[$];
  bit   freeb [2];
  int   ndone, run_start, last_end, lat;
  bit   run, cerr;

  task automatic model_reset();
    q.delete();
    freeb[0] = 1'b1;
    freeb[1] = 1'b1;
    ndone = 0; run = 1'b0; run_start = 0; last_end = -100; cerr = 1'b0; t = 0; lat = 1;
  endtask

  task automatic cyc(input bit cm, input int md, input bit ak, input bit dn, input bit auto_core);
    bit e_fv, e_start, e_abort, fin, fin_err, d, rv;
    int e_fb;
    job_t j;
    @(negedge clk);
    e_start = 1'b0;
    if (!run && ndone < q.size() && t >= q[ndone].cc + 2 && t >= last_end + 2) begin
      run = 1'b1; run_start = t; e_start = 1'b1;
      lat = $urandom_range(1, 20);
    end
    d = dn;
    if (auto_core)
      d = (run && t == run_start + lat) || (!(run && t > run_start) && $urandom_range(0, 9) == 0);
    job_commit = cm; job_mode = md[0]; res_ack = ak; core_done = d;
    e_fv = 1'b0; e_fb = 0;
    for (int i = 1; i >= 0; i--) if (freeb[i]) begin e_fv = 1'b1; e_fb = i; end
    fin = 1'b0; fin_err = 1'b0; e_abort = 1'b0;
    if (run && t > run_start) begin
      if (d) fin = 1'b1;
      else if (t == run_start + TMO) begin fin = 1'b1; fin_err = 1'b1; e_abort = 1'b1; end
    end
    rv = (ndone > 0);
    #1;
    chk("fill_valid", int'(fill_valid), int'(e_fv));
    if (e_fv) chk("fill_bank", int'(fill_bank), e_fb);
    chk("pending", int'(pending), q.size());
    chk("res_valid", int'(res_valid), int'(rv));
    if (rv) begin
      chk("res_bank", int'(res_bank), q[0].bank);
      chk("res_mode", int'(res_mode), q[0].mode);
      chk("res_err", int'(res_err), int'(q[0].err));
    end
    chk("core_start", int'(core_start), int'(e_start));
    chk("core_abort", int'(core_abort), int'(e_abort));
    chk("busy", int'(busy), int'(run));
    chk("commit_err", int'(commit_err), int'(cerr));
    if (run) begin
      chk("core_bank", int'(core_bank), q[ndone].bank);
      chk("core_mode", int'(core_mode), q[ndone].mode);
    end
    if (fin) begin
      q[ndone].err = fin_err;
      ndone++; run = 1'b0; last_end = t;
    end
    if (ak && rv) begin
      freeb[q[0].bank] = 1'b1;
      void'(q.pop_front());
      ndone--;
    end
    if (cm) begin
      if (e_fv) begin
        j.bank = e_fb; j.mode = md & 1; j.cc = t; j.err = 1'b0;
        q.push_back(j);
        freeb[e_fb] = 1'b0;
      end else cerr = 1'b1;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    job_commit = 1'b0; job_mode = 1'b0; core_done = 1'b0; res_ack = 1'b0;
    b_commit = 1'b0; b_mode = 1'b0; b_done = 1'b0; b_ack = 1'b0;
    #1;
    chk("rst_fill_valid", int'(fill_valid), 1);
    chk("rst_fill_bank", int'(fill_bank), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_core_start", int'(core_start), 0);
    chk("rst_core_abort", int'(core_abort), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_commit_err", int'(commit_err), 0);
    chk("rst_core_bank", int'(core_bank), 0);
    chk("rst4_pending", int'(b_pending), 0);
    chk("rst4_fill_valid", int'(b_fill_valid), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_no_abort", int'(core_abort), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cyc4(input bit cm, input bit md, input bit ak, input bit dn);
    @(negedge clk);
    b_commit = cm; b_mode = md; b_ack = ak; b_done = dn;
    #1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single job through the whole flow
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t1_fill_bank", int'(fill_bank), 1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t1_start", int'(core_start), 1);
    chk("t1_core_bank", int'(core_bank), 0);
    chk("t1_core_mode", int'(core_mode), 1);
    idle(7);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t1_res_valid", int'(res_valid), 1);
    chk("t1_res_mode", int'(res_mode), 1);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t1_refill", int'(fill_bank), 0);

    // Fill both banks, then overcommit
    do_reset();
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("t2_full", int'(fill_valid), 0);
    chk("t2_start0_bank", int'(core_bank), 0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t2_commit_err", int'(commit_err), 1);
    chk("t2_pending", int'(pending), 2);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t2_start1", int'(core_start), 1);
    chk("t2_start1_bank", int'(core_bank), 1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t2_drained", int'(pending), 0);

    // Watchdog expiry, then done on the last watchdog cycle
    do_reset();
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    idle(16);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t3_abort", int'(core_abort), 1);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("t3_res_err", int'(res_err), 1);
    chk("t3_res_bank", int'(res_bank), 0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("t3_restart", int'(core_start), 1);
    chk("t3_restart_bank", int'(core_bank), 1);
    idle(15);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t4_no_abort", int'(core_abort), 0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("t4_res_valid", int'(res_valid), 1);
    chk("t4_res_err", int'(res_err), 0);
    chk("t4_res_bank", int'(res_bank), 1);
    idle(1);

    // Asynchronous reset while the core is waiting
    do_reset();
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("t6_pending_pre", int'(pending), 2);
    chk("t6_busy_pre", int'(busy), 1);
    do_reset();

    // 4 banks: commit and ack in one cycle, watchdog disabled
    cyc4(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b_fill0", int'(b_fill_bank), 0);
    cyc4(1'b1, 1'b1, 1'b0, 1'b0);
    chk("b_fill1", int'(b_fill_bank), 1);
    cyc4(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_start0", int'(b_core_start), 1);
    chk("b_start0_bank", int'(b_core_bank), 0);
    chk("b_pending2", int'(b_pending), 2);
    cyc4(1'b0, 1'b0, 1'b0, 1'b0);
    cyc4(1'b0, 1'b0, 1'b0, 1'b1);
    cyc4(1'b1, 1'b1, 1'b1, 1'b0);
    chk("b_res_valid", int'(b_res_valid), 1);
    chk("b_fill2", int'(b_fill_bank), 2);
    chk("b_pending_pre", int'(b_pending), 2);
    cyc4(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_pending_post", int'(b_pending), 2);
    chk("b_refill0", int'(b_fill_bank), 0);
    chk("b_start1", int'(b_core_start), 1);
    chk("b_start1_bank", int'(b_core_bank), 1);
    for (int i = 0; i < 40; i++) begin
      cyc4(1'b0, 1'b0, 1'b0, 1'b0);
      chk("b_no_abort", int'(b_core_abort), 0);
    end
    chk("b_still_busy", int'(b_busy), 1);
    cyc4(1'b0, 1'b0, 1'b0, 1'b1);
    cyc4(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_res1_valid", int'(b_res_valid), 1);
    chk("b_res1_bank", int'(b_res_bank), 1);
    cyc4(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_start2", int'(b_core_start), 1);
    chk("b_start2_bank", int'(b_core_bank), 2);
    chk("b_start2_mode", int'(b_core_mode), 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_job_sched.md
Name: decode_job_sched

Overview:
- Job scheduler for the polynomial decoder datapath.
- Generalises the single-buffer, single-mode decode path to NBANK paired input/output RAM banks and 2^MODE_W parameter sets (rq, rounded, future sets).
- The host fills a free bank, then commits it as a job with a mode. The block dispatches jobs in order to one decoder core, watchdogs the core, and returns results in commit order.
- Sits between the host bus and the decode core / bank-select muxes.

Parameters:
- NBANK, 2: number of bank pairs; power of two, 2..8.
- BANK_W, 1: log2(NBANK).
- MODE_W, 1: job mode width; selects the parameter ROM set.
- TMO_W, 16: watchdog counter width.
- TMO_CYC, 0: core cycles allowed per job; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fill_valid  out  1  a free bank exists
- fill_bank  out  BANK_W  lowest-index free bank; host loads this bank
- job_commit  in  1  pulse: fill_bank loaded, enqueue it
- job_mode  in  MODE_W  mode for the committed job
- core_start  out  1  one-cycle start pulse to the decoder
- core_bank  out  BANK_W  bank the core reads and writes
- core_mode  out  MODE_W  parameter-set select
- core_done  in  1  decoder completion pulse
- core_abort  out  1  one-cycle pulse on watchdog expiry
- res_valid  out  1  oldest job finished, result readable
- res_bank  out  BANK_W  bank holding that result
- res_mode  out  MODE_W  mode of that job
- res_err  out  1  that job timed out
- res_ack  in  1  pulse: result consumed, release the bank
- busy  out  1  core FSM not IDLE
- pending  out  BANK_W+1  jobs committed and not yet acked
- commit_err  out  1  sticky: commit seen while fill_valid=0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Bank bitmap all free, all ring pointers 0, FSM IDLE.
  - All outputs 0, except fill_valid=1 and fill_bank=0.
- Ring storage:
  - NBANK entries, each holding {bank, mode, err, done}.
  - Pointers: wr (commit), dsp (dispatch), rd (retire).
  - Occupancy equals pending, which is at most NBANK.
  - in_use[NBANK] bitmap; fill_bank and fill_valid are combinational from ~in_use via a lowest-index priority encoder.
- Commit:
  - job_commit=1 with fill_valid=1: ring[wr] is written with fill_bank, job_mode, err=0, done=0; in_use is set; wr advances mod NBANK.
  - job_commit=1 with fill_valid=0: the commit is ignored and commit_err is set until reset.
- Core FSM states: IDLE, START, WAIT.
  - IDLE -> START when dsp != wr. core_bank and core_mode load from ring[dsp].
  - START: core_start=1 for exactly this cycle; watchdog clears to 0; go to WAIT.
  - WAIT -> IDLE on core_done: ring[dsp].done=1, dsp advances.
  - WAIT -> IDLE on watchdog expiry (TMO_CYC!=0 and count==TMO_CYC-1 without core_done): core_abort=1 for one cycle, ring[dsp] gets done=1 and err=1, dsp advances.
  - core_done and expiry in the same cycle: done wins, no abort, err=0.
  - core_done outside WAIT is ignored.
  - core_bank and core_mode stay stable from START until leaving WAIT.
- Latency:
  - Commit sampled in cycle k with the FSM IDLE and ring empty: core_start is high in cycle k+2 (IDLE sees the entry in k+1, START in k+2).
  - core_done sampled in cycle d: res_valid is high from cycle d+1.
  - The next core_start is no earlier than d+2.
- Results:
  - res_valid = ring[rd].done and occupancy>0. res_bank, res_mode and res_err come from ring[rd].
  - res_ack=1 with res_valid=1: in_use[res_bank] clears and rd advances. The freed bank is visible on fill_bank from the next cycle.
  - res_ack=1 with res_valid=0 is ignored.
- Simultaneous events:
  - commit and ack in the same cycle: both apply; pending is unchanged.
  - commit, ack and dispatch in the same cycle: all three pointers update independently.
- Ordering: results always retire in commit order. A bank is never re-offered on fill_bank before its ack.
- Reset mid-job: everything is cleared, no abort pulse is issued, and jobs in flight are lost. The core shares rst_n.

Test Plan:
- NBANK=2: reset, then commit mode=1 at cycle 0.
  - fill_bank goes 0->1.
  - core_start is high at cycle 2 with core_bank=0, core_mode=1.
  - core_done at cycle 10 gives res_valid=1 at cycle 11 with res_bank=0, res_mode=1.
  - ack at cycle 12 makes fill_bank=0 at cycle 13.
- Two back-to-back commits (modes 0 and 1), then a third commit.
  - fill_valid=0 after the second commit.
  - The third commit sets commit_err=1; pending stays 2.
  - Jobs dispatch on banks 0 then 1.
- TMO_CYC=16, core_done withheld.
  - core_abort pulses 16 cycles after core_start.
  - res_err=1 and res_bank=0.
  - The next queued job starts 2 cycles after the abort.
- core_done coincides with the last watchdog cycle: no core_abort, res_err=0.
- commit and ack in the same cycle with pending=2: pending stays 2, and the acked bank is offered on the following cycle.
- rst_n pulled low during WAIT with 2 jobs pending: outputs return to reset values asynchronously, pending=0, and no core_abort is issued.
